iter_divider: RTL and testbench

Parametrised multi-cycle integer divider implementing RISC-V M-extension DIV/DIVU/REM/REMU on XLEN-bit operands. It performs one restoring remainder step per clock through a single shared subtract-and-select stage, with sign pre- and post-processing and RISC-V special-case results. It sits behind the execute stage as a long-latency functional unit, with valid/ready handshakes on both sides and a flush input for pipeline kills.

---
 rtl/div_pkg.sv | 27 ++
 rtl/remainder_step.sv | 25 ++
 rtl/iter_divider.sv | 150 +++++++++++++++
 tb/tb_iter_divider.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative RISC-V M-extension divider.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } div_state_e;

  function automatic logic is_signed(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/remainder_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module remainder_step #(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic            bit_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // Trial subtraction and restore select; the kept remainder is always below
  // the divisor, so its top bit is zero and only XLEN bits are carried.
  always_comb begin
    shifted  = {rem, bit_in};
    trial    = shifted - {1'b0, divisor};
    q_bit    = ~trial[XLEN];
    rem_next = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle DIV/DIVU/REM/REMU unit, one quotient bit per clock.
// Optional build macro: DIV_FAST_SPECIAL_EN (divide-by-zero and signed
// overflow resolve in PREP and skip the iterative steps).
module iter_divider
  import div_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_dividend,
  input  logic [XLEN-1:0] in_divisor,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state, state_next;
  div_op_e         op_q;
  logic [XLEN-1:0] a_q, b_q, q_q, r_q, d_q, result_q;
  logic [CNT_W-1:0] count_q;
  logic            neg_q_q, neg_r_q, div_zero_q, ovf_q;

  logic            a_neg, b_neg, prep_div_zero, prep_ovf, special_now, calc_last;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN-1:0] step_rem;
  logic            step_q;
  logic [XLEN-1:0] q_fix, r_fix, fix_result;

  remainder_step #(.XLEN(XLEN)) u_step (
    .rem      (r_q),
    .bit_in   (q_q[XLEN-1]),
    .divisor  (d_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // Operand conditioning and special-case detection on the latched request.
  always_comb begin
    a_neg         = is_signed(op_q) & a_q[XLEN-1];
    b_neg         = is_signed(op_q) & b_q[XLEN-1];
    a_abs         = a_neg ? (~a_q + 1'b1) : a_q;
    b_abs         = b_neg ? (~b_q + 1'b1) : b_q;
    prep_div_zero = (b_q == '0);
    prep_ovf      = is_signed(op_q) && (a_q == MIN) && (b_q == '1);
    calc_last     = (count_q == CNT_W'(XLEN - 1));
`ifdef DIV_FAST_SPECIAL_EN
    special_now   = prep_div_zero | prep_ovf;
`else
    special_now   = 1'b0;
`endif
  end

  // Sign fix-up of the raw quotient/remainder followed by RISC-V overrides.
  always_comb begin
    q_fix = neg_q_q ? (~q_q + 1'b1) : q_q;
    r_fix = neg_r_q ? (~r_q + 1'b1) : r_q;
    if (div_zero_q) begin
      q_fix = '1;
      r_fix = a_q;
    end else if (ovf_q) begin
      q_fix = MIN;
      r_fix = '0;
    end
    fix_result = is_rem(op_q) ? r_fix : q_fix;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; flush wins over every other transition.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (in_valid) state_next = S_PREP;
      S_PREP: state_next = special_now ? S_DONE : S_CALC;
      S_CALC: if (calc_last) state_next = S_FIX;
      S_FIX:  state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  // Datapath registers, advanced according to the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= OP_DIV;
      a_q        <= '0;
      b_q        <= '0;
      q_q        <= '0;
      r_q        <= '0;
      d_q        <= '0;
      result_q   <= '0;
      count_q    <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (!flush) begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_q <= div_op_e'(in_op);
          a_q  <= in_dividend;
          b_q  <= in_divisor;
        end
        S_PREP: begin
          q_q        <= a_abs;
          r_q        <= '0;
          d_q        <= b_abs;
          count_q    <= '0;
          neg_q_q    <= a_neg ^ b_neg;
          neg_r_q    <= a_neg;
          div_zero_q <= prep_div_zero;
          ovf_q      <= prep_ovf;
`ifdef DIV_FAST_SPECIAL_EN
          if (prep_div_zero)
            result_q <= is_rem(op_q) ? a_q : '1;
          else if (prep_ovf)
            result_q <= is_rem(op_q) ? '0 : MIN;
`endif
        end
        S_CALC: begin
          r_q     <= step_rem;
          q_q     <= {q_q[XLEN-2:0], step_q};
          count_q <= count_q + CNT_W'(1);
        end
        S_FIX: result_q <= fix_result;
        default: ;
      endcase
    end
  end

  assign in_ready   = (state == S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign out_result = result_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider (XLEN=64 and XLEN=32).
module tb_iter_divider;

  localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 66;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v64 = 0, rdy64, fl64 = 0, ov64, or64 = 0, busy64;
  logic [1:0]  op64 = '0;
  logic [63:0] a64 = '0, b64 = '0, res64;

  logic        v32 = 0, rdy32, fl32 = 0, ov32, or32 = 0, busy32;
  logic [1:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0, res32;

  iter_divider #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64), .in_op(op64),
    .in_dividend(a64), .in_divisor(b64), .flush(fl64), .out_valid(ov64),
    .out_ready(or64), .out_result(res64), .busy(busy64)
  );

  iter_divider #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .in_op(op32),
    .in_dividend(a32), .in_divisor(b32), .flush(fl32), .out_valid(ov32),
    .out_ready(or32), .out_result(res32), .busy(busy32)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int lat;
  logic seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic start64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    op64 = op; a64 = a; b64 = b; v64 = 1'b1;
    @(posedge clk); #1;
    v64 = 1'b0;
  endtask

  task automatic wait64(output int l);
    l = 0;
    while (!ov64 && l < 200) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic take64();
    or64 = 1'b1;
    @(posedge clk); #1;
    or64 = 1'b0;
  endtask

  task automatic op_check64(input string tag, input logic [1:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    start64(op, a, b);
    wait64(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check(tag, res64, exp);
    take64();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(rdy64),  64'd1);
    check("rst_out_valid", 64'(ov64),   64'd0);
    check("rst_busy",      64'(busy64), 64'd0);
    check("rst_result",    res64,       64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // DIVU 100/7 with latency and hold checks
    start64(DIVU, 64'd100, 64'd7);
    check("accept_busy", 64'(busy64), 64'd1);
    wait64(lat);
    check("divu_lat", 64'(lat), 64'd66);
    check("divu_100_7", res64, 64'd14);
    check("done_in_ready", 64'(rdy64), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("hold_valid",  64'(ov64), 64'd1);
    check("hold_result", res64,     64'd14);
    take64();
    check("taken_valid", 64'(ov64),  64'd0);
    check("taken_ready", 64'(rdy64), 64'd1);

    op_check64("remu_100_7", REMU, 64'd100, 64'd7, 64'd2, 66);
    op_check64("div_m7_2",  DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    op_check64("rem_m7_2",  REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 66);
    op_check64("rem_7_m2",  REM, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66);
    op_check64("div_5_0",   DIV,  64'd5, 64'd0, ONES, SPECIAL_LAT);
    op_check64("remu_5_0",  REMU, 64'd5, 64'd0, 64'd5, SPECIAL_LAT);
    op_check64("div_ovf",   DIV, MIN64, ONES, MIN64, SPECIAL_LAT);
    op_check64("rem_ovf",   REM, MIN64, ONES, 64'd0, SPECIAL_LAT);

    // flush in cycle 20 of CALC
    start64(DIVU, 64'd1000, 64'd3);
    repeat (21) @(posedge clk);
    #1;
    check("pre_flush_busy", 64'(busy64), 64'd1);
    fl64 = 1'b1;
    @(posedge clk); #1;
    fl64 = 1'b0;
    check("flush_busy",  64'(busy64), 64'd0);
    check("flush_ready", 64'(rdy64),  64'd1);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (ov64) seen = 1'b1;
    end
    check("flush_no_valid", 64'(seen), 64'd0);

    // flush beats in_valid in IDLE
    v64 = 1'b1; fl64 = 1'b1;
    @(posedge clk); #1;
    v64 = 1'b0; fl64 = 1'b0;
    check("flush_idle_busy", 64'(busy64), 64'd0);

    op_check64("divu_9_3", DIVU, 64'd9, 64'd3, 64'd3, 66);

    // async reset mid-CALC
    start64(DIVU, 64'd100, 64'd7);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(ov64),   64'd0);
    check("arst_busy",  64'(busy64), 64'd0);
    check("arst_ready", 64'(rdy64),  64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // XLEN=32 repeat of DIVU 100/7
    op32 = DIVU; a32 = 32'd100; b32 = 32'd7; v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0;
    lat = 0;
    while (!ov32 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("x32_lat",    64'(lat),          64'd34);
    check("x32_divu",   {32'd0, res32},    64'd14);
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
    check("x32_taken",  64'(ov32),         64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
